// File: rtl/i2c_sched_pkg.sv
// Shared types for the I2C request scheduler: FSM state encoding and the
// status codes returned to requesters alongside their done pulse.
package i2c_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RESP      = 2'd3
  } sched_state_e;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_NACK    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

endpackage

// File: rtl/i2c_req_scheduler_rr_pick.sv
// Round-robin winner selection: first set request bit found searching
// upward from the slot after rr_ptr, wrapping at NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [IDX_W-1:0]   win_idx
);

  logic found;
  int   j;

  // Scan NUM_REQ slots starting just after the last winner; first hit wins.
  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    found      = 1'b0;
    j          = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req[j]) begin
        found         = 1'b1;
        win_onehot[j] = 1'b1;
        win_idx       = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/i2c_req_scheduler.sv
// Fair round-robin scheduler sharing one i2c_master between NUM_REQ clients.
// Latches the winning request, drives the master, watches its busy line with
// a timeout, and returns read data plus status with a one-cycle done pulse.
module i2c_req_scheduler
  import i2c_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 200000,
  parameter int CNT_W       = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [7*NUM_REQ-1:0] req_addr,
  input  logic [NUM_REQ-1:0]   req_rw,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic [7:0]           rdata,
  output logic [1:0]           status,
  output logic                 m_start,
  output logic [6:0]           m_addr,
  output logic [7:0]           m_data,
  output logic                 m_rw,
  input  logic                 m_busy,
  input  logic [7:0]           m_data_out,
  input  logic                 m_ack_error
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  sched_state_e state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               m_start_q, m_start_d;
  logic [6:0]         m_addr_q, m_addr_d;
  logic [7:0]         m_data_q, m_data_d;
  logic               m_rw_q, m_rw_d;
  logic [7:0]         rdata_q, rdata_d;
  logic [1:0]         status_q, status_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hold_q, hold_d;
  logic               busy_meta_q, busy_s_q;

  logic [NUM_REQ-1:0] win_onehot;
  logic [IDX_W-1:0]   win_idx;
  logic [6:0]         sel_addr;
  logic [7:0]         sel_wdata;
  logic               sel_rw;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req        (req),
    .rr_ptr     (rr_ptr_q),
    .win_onehot (win_onehot),
    .win_idx    (win_idx)
  );

  // Mux the winner's transaction fields out of the flattened request buses.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_rw    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_onehot[i]) begin
        sel_addr  = req_addr[i*7 +: 7];
        sel_wdata = req_wdata[i*8 +: 8];
        sel_rw    = req_rw[i];
      end
    end
  end

  // Two-flop synchroniser for the master's busy line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_meta_q <= 1'b0;
      busy_s_q    <= 1'b0;
    end else begin
      busy_meta_q <= m_busy;
      busy_s_q    <= busy_meta_q;
    end
  end

  // Next-state logic: arbitration, master handshake, timeout and response.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    done_d    = '0;
    m_start_d = m_start_q;
    m_addr_d  = m_addr_q;
    m_data_d  = m_data_q;
    m_rw_d    = m_rw_q;
    rdata_d   = rdata_q;
    status_d  = status_q;
    cnt_d     = cnt_q;
    hold_d    = 1'b0;
    case (state_q)
      IDLE: begin
        // hold_q masks the cycle right after RESP, when the finished
        // requester may not yet have dropped its req.
        if (!hold_q && (|req)) begin
          grant_d   = win_onehot;
          rr_ptr_d  = win_idx;
          m_addr_d  = sel_addr;
          m_data_d  = sel_wdata;
          m_rw_d    = sel_rw;
          m_start_d = 1'b1;
          cnt_d     = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        // start stays high until the master, on its slow tick, reports busy.
        if (busy_s_q) begin
          m_start_d = 1'b0;
          cnt_d     = '0;
          state_d   = WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          m_start_d = 1'b0;
          status_d  = ST_TIMEOUT;
          done_d    = grant_q;
          grant_d   = '0;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!busy_s_q) begin
          if (m_rw_q) rdata_d = m_data_out;
          status_d = m_ack_error ? ST_NACK : ST_OK;
          done_d   = grant_q;
          grant_d  = '0;
          state_d  = RESP;
        end else if (cnt_q == CNT_LAST) begin
          status_d = ST_TIMEOUT;
          done_d   = grant_q;
          grant_d  = '0;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        hold_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= IDX_W'(NUM_REQ - 1);
      grant_q   <= '0;
      done_q    <= '0;
      m_start_q <= 1'b0;
      m_addr_q  <= '0;
      m_data_q  <= '0;
      m_rw_q    <= 1'b0;
      rdata_q   <= '0;
      status_q  <= ST_OK;
      cnt_q     <= '0;
      hold_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      m_start_q <= m_start_d;
      m_addr_q  <= m_addr_d;
      m_data_q  <= m_data_d;
      m_rw_q    <= m_rw_d;
      rdata_q   <= rdata_d;
      status_q  <= status_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
    end
  end

  assign grant   = grant_q;
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign status  = status_q;
  assign m_start = m_start_q;
  assign m_addr  = m_addr_q;
  assign m_data  = m_data_q;
  assign m_rw    = m_rw_q;

endmodule

// File: tb/tb_i2c_req_scheduler.sv
// Self-checking bench for i2c_req_scheduler with a behavioural i2c_master
// model and a scoreboard of expected transactions.
module tb_i2c_req_scheduler;

  localparam int NUM_REQ = 4;
  localparam int TO_CYC  = 50;
  localparam int CNT_W   = 8;
  localparam int M_NORMAL = 0, M_NOBUSY = 1, M_STUCK = 2;
  localparam int LIMIT   = 400;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req;
  logic [7*NUM_REQ-1:0] req_addr;
  logic [NUM_REQ-1:0]   req_rw;
  logic [8*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]   grant, done;
  logic [7:0]           rdata;
  logic [1:0]           status;
  logic                 m_start, m_rw, m_busy, m_ack_error;
  logic [6:0]           m_addr;
  logic [7:0]           m_data, m_data_out;

  i2c_req_scheduler #(
    .NUM_REQ     (NUM_REQ),
    .TIMEOUT_CYC (TO_CYC),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_addr    (req_addr),
    .req_rw      (req_rw),
    .req_wdata   (req_wdata),
    .grant       (grant),
    .done        (done),
    .rdata       (rdata),
    .status      (status),
    .m_start     (m_start),
    .m_addr      (m_addr),
    .m_data      (m_data),
    .m_rw        (m_rw),
    .m_busy      (m_busy),
    .m_data_out  (m_data_out),
    .m_ack_error (m_ack_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    logic [7:0] mdo;
    logic       ack;
    int         mode;
    logic [1:0] st;
    logic [7:0] rd;
  } vec_t;

  typedef struct {
    int         idx;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       rw;
    logic [1:0] st;
    logic [7:0] rd;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int mmode = M_NORMAL;
  logic [7:0] mdo = 8'h00;
  logic mack = 1'b0;
  int start_len = 0;
  int run_len = 0;
  logic prev_start = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural i2c_master: busy rises 2 cycles after start, falls later.
  initial begin
    int k;
    m_busy = 1'b0; m_data_out = 8'h00; m_ack_error = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && m_start && !m_busy && mmode != M_NOBUSY) begin
        repeat (2) @(negedge clk);
        m_busy = 1'b1;
        if (mmode == M_STUCK) begin
          k = 0;
          while (rst_n && k < 200) begin @(negedge clk); k++; end
        end else begin
          repeat (4) @(negedge clk);
        end
        m_data_out = mdo; m_ack_error = mack; m_busy = 1'b0;
      end
    end
  end

  // Scoreboard monitor: checks master drive at start and results at done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (m_start && !prev_start) begin
          if (q.size() == 0) chk("start_unexpected", 32'(m_start), 32'd0);
          else begin
            e = q[0];
            chk("grant", 32'(grant), 32'(1) << e.idx);
            chk("m_addr", 32'(m_addr), 32'(e.addr));
            chk("m_data", 32'(m_data), 32'(e.wdata));
            chk("m_rw", 32'(m_rw), 32'(e.rw));
          end
        end
        if (done != '0) begin
          if (q.size() == 0) chk("done_unexpected", 32'(done), 32'd0);
          else begin
            e = q.pop_front();
            chk("done", 32'(done), 32'(1) << e.idx);
            chk("status", 32'(status), 32'(e.st));
            chk("rdata", 32'(rdata), 32'(e.rd));
            chk("grant_cleared", 32'(grant), 32'd0);
          end
        end
      end
      if (!rst_n) run_len = 0;
      else if (m_start) run_len++;
      else if (prev_start) begin start_len = run_len; run_len = 0; end
      prev_start = m_start;
    end
  end

  task automatic set_fields(input int idx, input logic [6:0] a, input logic rw, input logic [7:0] wd);
    req_addr[idx*7 +: 7]  = a;
    req_rw[idx]           = rw;
    req_wdata[idx*8 +: 8] = wd;
  endtask

  task automatic push_exp(input int idx, input logic [6:0] a, input logic [7:0] wd,
                          input logic rw, input logic [1:0] st, input logic [7:0] rd);
    exp_t e;
    e.idx = idx; e.addr = a; e.wdata = wd; e.rw = rw; e.st = st; e.rd = rd;
    q.push_back(e);
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (done == '0 && n < LIMIT) begin @(negedge clk); n++; end
    if (done == '0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle_bus();
    int n = 0;
    while (m_busy && n < LIMIT) begin @(negedge clk); n++; end
    if (m_busy) chk("busy_release_timeout", 32'd1, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  vec_t vecs[7];

  initial begin
    int n;
    vecs[0] = '{2, 7'h50, 1'b0, 8'hA5, 8'h00, 1'b0, M_NORMAL, 2'b00, 8'h00};
    vecs[1] = '{1, 7'h3C, 1'b1, 8'h00, 8'h5A, 1'b0, M_NORMAL, 2'b00, 8'h5A};
    vecs[2] = '{1, 7'h3C, 1'b1, 8'h00, 8'h77, 1'b1, M_NORMAL, 2'b01, 8'h77};
    vecs[3] = '{3, 7'h22, 1'b0, 8'h3E, 8'h00, 1'b1, M_NORMAL, 2'b01, 8'h77};
    vecs[4] = '{0, 7'h11, 1'b0, 8'h44, 8'h00, 1'b0, M_NOBUSY, 2'b10, 8'h77};
    vecs[5] = '{2, 7'h48, 1'b1, 8'h00, 8'h99, 1'b0, M_STUCK,  2'b10, 8'h77};
    vecs[6] = '{3, 7'h2A, 1'b1, 8'h00, 8'hC3, 1'b0, M_NORMAL, 2'b00, 8'hC3};

    rst_n = 1'b0; req = '0; req_addr = '0; req_rw = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_outs", {done, status, m_start, m_rw}, 32'd0);
    chk("rst_data", {m_addr, m_data, rdata}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Round-robin with all requests held: 0,1,2,3,0.
    for (int i = 0; i < NUM_REQ; i++) set_fields(i, 7'(7'h10 + i), 1'b0, 8'(8'h20 + i));
    for (int t = 0; t < 5; t++) push_exp(t % NUM_REQ, 7'(7'h10 + t % NUM_REQ), 8'(8'h20 + t % NUM_REQ), 1'b0, 2'b00, 8'h00);
    req = '1;
    for (int t = 0; t < 5; t++) wait_done();
    req = '0;
    wait_idle_bus();
    chk("rr_queue_drained", 32'(q.size()), 32'd0);

    // Table-driven single transactions.
    for (int v = 0; v < 7; v++) begin
      mmode = vecs[v].mode; mdo = vecs[v].mdo; mack = vecs[v].ack;
      set_fields(vecs[v].idx, vecs[v].addr, vecs[v].rw, vecs[v].wdata);
      push_exp(vecs[v].idx, vecs[v].addr, vecs[v].wdata, vecs[v].rw, vecs[v].st, vecs[v].rd);
      req[vecs[v].idx] = 1'b1;
      wait_done();
      req = '0;
      @(negedge clk);
      if (vecs[v].mode == M_NOBUSY) chk("start_high_len", 32'(start_len), 32'(TO_CYC));
      wait_idle_bus();
    end
    chk("tbl_queue_drained", 32'(q.size()), 32'd0);

    // Reset in WAIT_DONE: outputs clear asynchronously, no done, ptr reset.
    mmode = M_STUCK; mdo = 8'h00; mack = 1'b0;
    set_fields(1, 7'h3C, 1'b1, 8'h00);
    push_exp(1, 7'h3C, 8'h00, 1'b1, 2'b00, 8'h00);
    req[1] = 1'b1;
    n = 0;
    while (!m_start && n < LIMIT) begin @(negedge clk); n++; end
    while (m_start && n < LIMIT) begin @(negedge clk); n++; end
    if (n >= LIMIT) chk("reach_wait_done", 32'd0, 32'd1);
    repeat (3) @(negedge clk);
    chk("pre_rst_grant", 32'(grant), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_grant", 32'(grant), 32'd0);
    chk("arst_outs", {done, status, m_start, m_rw}, 32'd0);
    chk("arst_data", {m_addr, m_data, rdata}, 32'd0);
    q.delete();
    req = '0;
    repeat (3) @(negedge clk);
    chk("rst_no_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    mmode = M_NORMAL;
    @(negedge clk);
    set_fields(0, 7'h33, 1'b0, 8'h66);
    set_fields(3, 7'h2A, 1'b1, 8'h00);
    push_exp(0, 7'h33, 8'h66, 1'b0, 2'b00, 8'h00);
    req = 4'b1001;
    wait_done();
    req = '0;
    wait_idle_bus();
    chk("final_grant_idle", 32'(grant), 32'd0);
    chk("final_queue_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2c_req_scheduler.md
Name: i2c_req_scheduler

Overview:
Shares one i2c_master between NUM_REQ independent requesters with a fair round-robin policy. Each requester posts a single-byte transaction (7-bit address, R/W, write byte). The block:
- latches the winning request;
- drives the master's start/addr/data_in/rw;
- tracks the master's busy handshake and applies a timeout;
- returns read data and a status code to the winner with a one-cycle done pulse.
It sits between the system-side clients (sensor pollers, config loader) and the i2c_master instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYC, 200000, clk cycles allowed for master busy to rise after start, and again for busy to fall
CNT_W, 18, width of timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC

Ports:
clk  in  1  system clock (100 MHz)
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester request level; held high until matching done pulse
req_addr  in  7*NUM_REQ  flattened 7-bit target addresses, requester i at [7i+6:7i]
req_rw  in  NUM_REQ  per-requester 0=write, 1=read
req_wdata  in  8*NUM_REQ  flattened write bytes, requester i at [8i+7:8i]
grant  out  NUM_REQ  one-hot owner of current transaction, 0 when idle
done  out  NUM_REQ  one-cycle pulse to owner when transaction ends
rdata  out  8  read byte, valid in done cycle and held until next done
status  out  2  00=ok, 01=NACK (ack_error), 10=timeout; valid with done, held
m_start  out  1  to i2c_master start
m_addr  out  7  to i2c_master addr
m_data  out  8  to i2c_master data_in
m_rw  out  1  to i2c_master rw
m_busy  in  1  from i2c_master busy (treated as asynchronous; 2-flop synchronised internally)
m_data_out  in  8  from i2c_master data_out
m_ack_error  in  1  from i2c_master ack_error

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; rr_ptr=NUM_REQ-1, so requester 0 wins first.
  - grant, done, m_start, m_addr, m_data, m_rw, rdata, status all 0; timeout counter 0.
- All outputs are registered.
- m_busy goes through a 2-flop synchroniser; all FSM decisions use busy_s.
- IDLE: if any req bit is set, choose winner w = first set bit searching (rr_ptr+1) mod NUM_REQ upward. Next cycle:
  - grant=onehot(w); rr_ptr=w;
  - m_addr/m_data/m_rw latched from w's fields;
  - m_start=1; state=ISSUE; counter cleared.
- ISSUE: m_start held high, because the master samples start only on its slow tick.
  - busy_s=1 -> m_start=0, counter cleared, state=WAIT_DONE.
  - Counter reaches TIMEOUT_CYC first -> m_start=0, status=10, state=RESP.
- WAIT_DONE: m_start=0; latched m_addr/m_data/m_rw held stable.
  - busy_s=0 -> capture rdata=m_data_out if m_rw=1 (else rdata unchanged); status = m_ack_error ? 01 : 00; state=RESP.
  - Counter reaches TIMEOUT_CYC first -> status=10, state=RESP.
- RESP: done[w]=1 for exactly one cycle, grant cleared, state=IDLE.
  - The requester drops req in the cycle after done.
  - IDLE ignores req for one cycle after RESP, so a not-yet-dropped req is not re-granted.
- Latency: request to m_start is 1 clk from IDLE. Minimum request to done is 3 clk plus master time.
- Arbitration:
  - Requests are changed only in IDLE. A req that deasserts while granted does not abort the transaction; done still pulses.
  - Simultaneous requests are resolved purely by rr_ptr.
  - Every requester is served within NUM_REQ transactions; a held req cannot starve.
- Req fields are sampled only at grant; later changes are ignored.
- A timeout does not reset the master. The FSM returns to IDLE, and the next grant proceeds normally.
- Reset mid-transaction returns to IDLE immediately with no done pulse.

Decomposition:
- Package i2c_sched_pkg:
  - state encoding IDLE/ISSUE/WAIT_DONE/RESP;
  - status codes ST_OK=2'b00, ST_NACK=2'b01, ST_TIMEOUT=2'b10.
- One sub-module rr_pick (combinational): inputs req vector and rr_ptr; outputs one-hot winner and winner index; parameterised on NUM_REQ.
- The FSM, synchroniser and timeout counter live in the top module.

Test Plan:
- Single write: req[2]=1, addr=7'h50, rw=0, wdata=8'hA5; slave ACKs -> grant=4'b0100, m_addr=7'h50, m_data=8'hA5, then done[2] pulse with status=00.
- Single read with NACK:
  - Read req[1], addr 7'h3C, master returns data_out=8'h5A, ack_error=0 -> rdata=8'h5A, status=00.
  - Same read with ack_error=1 -> status=01.
- Round-robin: req=4'b1111 held after each done -> grant order 0,1,2,3,0; no requester granted twice before all others.
- Start timeout: m_busy tied 0, TIMEOUT_CYC=50 -> m_start high for exactly 50 clk, then done pulse, status=10, FSM back in IDLE.
- Busy-stuck timeout: m_busy rises then stays 1 -> status=10 after TIMEOUT_CYC in WAIT_DONE; next req is granted normally.
- Reset mid-operation: assert rst_n low during WAIT_DONE -> all outputs 0 asynchronously, no done pulse; after release, req[0] is granted first.
